la_sample_buffer: RTL

//  Pre/post-trigger sample memory for the 4-channel logic analyzer. Sits directly

---
 rtl/la_sample_buffer.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/la_sample_buffer.sv
// Pre/post-trigger ring buffer for the 4-channel logic analyzer.
// Freezes a DEPTH-sample window around a masked-pattern trigger and streams it out oldest-first.
module la_sample_buffer #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int PRE   = 4
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          arm_i,
    input  logic [3:0]    in_data_i,
    input  logic [3:0]    trig_mask_i,
    input  logic [3:0]    trig_value_i,
    input  logic          rd_ready_i,
    output logic          rd_valid_o,
    output logic [3:0]    rd_data_o,
    output logic [AW-1:0] rd_index_o,
    output logic [2:0]    state_o,
    output logic [7:0]    out_data_o
);

    // state | meaning
    // IDLE  | waiting for a rising edge on arm, no writes
    // FILL  | collecting the first PRE samples, trigger ignored
    // ARMED | writing every cycle, looking for the trigger pattern
    // POST  | writing the post-trigger samples, post_cnt counts down
    // DONE  | window frozen, readout pointer set to the oldest sample
    // READ  | streaming the window out over valid/ready
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FILL  = 3'd1,
        ARMED = 3'd2,
        POST  = 3'd3,
        DONE  = 3'd4,
        READ  = 3'd5
    } state_t;

    localparam logic [AW-1:0] PRE_A     = AW'(PRE);
    localparam logic [AW-1:0] FILL_LAST = AW'(PRE - 1);
    localparam logic [AW-1:0] POST_INIT = AW'(DEPTH - PRE - 1);
    localparam logic [AW-1:0] LAST_IDX  = AW'(DEPTH - 1);
    localparam state_t        FIRST_ST  = (PRE == 1) ? ARMED : FILL;

    state_t        state_q;
    logic          arm_q;
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] trig_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW-1:0] rd_index_q;
    logic [AW-1:0] post_cnt_q;
    logic [3:0]    mem_q [DEPTH];

    logic arm_rise;
    logic match;
    logic capturing;
    logic wr_en_d;
    logic xfer;

    assign arm_rise  = arm_i & ~arm_q;
    assign match     = ((in_data_i ^ trig_value_i) & trig_mask_i) == 4'h0;
    assign capturing = (state_q == FILL) || (state_q == ARMED) || (state_q == POST);
    assign xfer      = rd_valid_o & rd_ready_i;

    // An abort (arm low while capturing) suppresses the write of that cycle.
    always_comb begin
        wr_en_d = 1'b0;
        if (state_q == IDLE && arm_rise)
            wr_en_d = 1'b1;
        else if (capturing && arm_i)
            wr_en_d = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (wr_en_d)
            mem_q[wr_ptr_q] <= in_data_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            arm_q      <= 1'b0;
            wr_ptr_q   <= '0;
            trig_ptr_q <= '0;
            rd_ptr_q   <= '0;
            rd_index_q <= '0;
            post_cnt_q <= '0;
        end else begin
            arm_q <= arm_i;
            if (wr_en_d)
                wr_ptr_q <= wr_ptr_q + AW'(1);

            case (state_q)
                IDLE: begin
                    if (arm_rise)
                        state_q <= FIRST_ST;
                end
                FILL: begin
                    if (!arm_i) begin
                        state_q  <= IDLE;
                        wr_ptr_q <= '0;
                    end else if (wr_ptr_q == FILL_LAST) begin
                        state_q <= ARMED;
                    end
                end
                ARMED: begin
                    if (!arm_i) begin
                        state_q  <= IDLE;
                        wr_ptr_q <= '0;
                    end else if (match) begin
                        trig_ptr_q <= wr_ptr_q;
                        post_cnt_q <= POST_INIT;
                        state_q    <= POST;
                    end
                end
                POST: begin
                    if (!arm_i) begin
                        state_q  <= IDLE;
                        wr_ptr_q <= '0;
                    end else begin
                        post_cnt_q <= post_cnt_q - AW'(1);
                        if (post_cnt_q == AW'(1))
                            state_q <= DONE;
                    end
                end
                DONE: begin
                    rd_ptr_q   <= trig_ptr_q - PRE_A;
                    rd_index_q <= '0;
                    wr_ptr_q   <= '0;
                    state_q    <= READ;
                end
                READ: begin
                    if (xfer) begin
                        rd_ptr_q   <= rd_ptr_q + AW'(1);
                        rd_index_q <= rd_index_q + AW'(1);
                        if (rd_index_q == LAST_IDX)
                            state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rd_valid_o = (state_q == READ);
    assign rd_data_o  = rd_valid_o ? mem_q[rd_ptr_q] : 4'h0;
    assign rd_index_o = rd_index_q;
    assign state_o    = state_q;
    assign out_data_o = {rd_valid_o, state_q, rd_data_o};

endmodule
